// File: rtl/duty_ramp.sv
`default_nettype none
// ============================================================================
// Module   : duty_ramp
// Brief    : Breathing duty-cycle sweep (rise, hold high, fall, hold low)
//            feeding the PWM generator. Optional macro GAMMA_EN selects a
//            square-law output curve instead of the linear duty.
// Revision : 1.0 - initial release
// ============================================================================
module duty_ramp #(
    parameter int STEP_CYCLES = 250000,
    parameter int STEP        = 1,
    parameter int DUTY_MAX    = 100,
    parameter int HOLD_STEPS  = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       pause,
    output logic [6:0] duty_cycle,
    output logic [1:0] phase,
    output logic       step_tick,
    output logic       peak
);

    localparam int              c_PW           = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int              c_HW           = (HOLD_STEPS > 0) ? $clog2(HOLD_STEPS + 1) : 1;
    localparam logic [c_PW-1:0] c_PRESC_LAST   = c_PW'(STEP_CYCLES - 1);
    localparam logic [c_HW-1:0] c_HOLD_STEPS   = c_HW'(HOLD_STEPS);
    localparam logic [6:0]      c_STEP         = 7'(STEP);
    localparam logic [7:0]      c_MAX          = 8'(DUTY_MAX);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RISE    = 3'd1,
        S_HOLD_HI = 3'd2,
        S_FALL    = 3'd3,
        S_HOLD_LO = 3'd4
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [c_PW-1:0] r_presc, w_presc_nxt;
    logic [c_HW-1:0] r_hold, w_hold_nxt, w_hold_inc;
    logic [6:0]      r_lin, w_lin_nxt;
    logic [1:0]      r_phase, w_phase_nxt;
    logic            r_tick, r_peak, w_peak_nxt, w_tick;
    logic [7:0]      w_sum;
    logic [6:0]      w_diff;

    always_comb begin
        w_tick      = (r_state != S_IDLE) && !pause && (r_presc == c_PRESC_LAST);
        w_sum       = {1'b0, r_lin} + {1'b0, c_STEP};
        w_diff      = (r_lin > c_STEP) ? (r_lin - c_STEP) : 7'd0;
        w_hold_inc  = r_hold + 1'b1;
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_hold_nxt  = r_hold;
        w_lin_nxt   = r_lin;
        w_peak_nxt  = 1'b0;

        // Dropping enable wins over pause and over a tick landing on the same edge
        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_presc_nxt = '0;
            w_hold_nxt  = '0;
            w_lin_nxt   = 7'd0;
        end else if (pause) begin
            w_state_nxt = r_state;
        end else if (r_state == S_IDLE) begin
            w_state_nxt = S_RISE;
            w_presc_nxt = '0;
            w_hold_nxt  = '0;
            w_lin_nxt   = 7'd0;
        end else begin
            w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                case (r_state)
                    S_RISE: begin
                        if (w_sum >= c_MAX) begin
                            w_lin_nxt   = c_MAX[6:0];
                            w_state_nxt = S_HOLD_HI;
                            w_hold_nxt  = '0;
                            w_peak_nxt  = 1'b1;
                        end else begin
                            w_lin_nxt = w_sum[6:0];
                        end
                    end
                    S_HOLD_HI: begin
                        if (w_hold_inc == c_HOLD_STEPS) begin
                            w_state_nxt = S_FALL;
                            w_hold_nxt  = '0;
                        end else begin
                            w_hold_nxt = w_hold_inc;
                        end
                    end
                    S_FALL: begin
                        w_lin_nxt = w_diff;
                        if (w_diff == 7'd0) begin
                            w_state_nxt = S_HOLD_LO;
                            w_hold_nxt  = '0;
                        end
                    end
                    S_HOLD_LO: begin
                        if (w_hold_inc == c_HOLD_STEPS) begin
                            w_state_nxt = S_RISE;
                            w_hold_nxt  = '0;
                        end else begin
                            w_hold_nxt = w_hold_inc;
                        end
                    end
                    default: w_state_nxt = S_IDLE;
                endcase
            end
        end

        case (w_state_nxt)
            S_RISE:    w_phase_nxt = 2'd1;
            S_HOLD_HI: w_phase_nxt = 2'd2;
            S_FALL:    w_phase_nxt = 2'd3;
            default:   w_phase_nxt = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_hold  <= '0;
            r_lin   <= 7'd0;
            r_phase <= 2'd0;
            r_tick  <= 1'b0;
            r_peak  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_hold  <= w_hold_nxt;
            r_lin   <= w_lin_nxt;
            r_phase <= w_phase_nxt;
            r_tick  <= w_tick && enable;
            r_peak  <= w_peak_nxt;
        end
    end

    assign phase     = r_phase;
    assign step_tick = r_tick;
    assign peak      = r_peak;

`ifdef GAMMA_EN
    logic [13:0] w_sq;
    logic [6:0]  w_gamma;
    logic [6:0]  r_gamma;

    // Rounded square law: (lin*lin + 50) / 100, fits 14 bits for lin <= 100
    always_comb begin
        w_sq    = 14'(r_lin) * 14'(r_lin);
        w_gamma = 7'((w_sq + 14'd50) / 14'd100);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gamma <= 7'd0;
        end else begin
            r_gamma <= w_gamma;
        end
    end

    assign duty_cycle = r_gamma;
`else
    assign duty_cycle = r_lin;
`endif

endmodule
`default_nettype wire

// File: tb/tb_duty_ramp.sv
`default_nettype none
// ============================================================================
// Module   : tb_duty_ramp
// Brief    : Randomized bench for duty_ramp; two builds (STEP 10 and STEP 30)
//            checked against a tick-indexed trajectory reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_duty_ramp;

    localparam int SC0 = 4, ST0 = 10, HD0 = 2;
    localparam int SC1 = 3, ST1 = 30, HD1 = 1;
    localparam int MX  = 100;

    logic       clk = 1'b0;
    logic       reset, enable, pause;
    logic [6:0] duty0, duty1;
    logic [1:0] ph0, ph1;
    logic       tk0, tk1, pk0, pk1;

    always #5 clk = ~clk;

    duty_ramp #(.STEP_CYCLES(SC0), .STEP(ST0), .DUTY_MAX(MX), .HOLD_STEPS(HD0)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .pause(pause),
        .duty_cycle(duty0), .phase(ph0), .step_tick(tk0), .peak(pk0)
    );

    duty_ramp #(.STEP_CYCLES(SC1), .STEP(ST1), .DUTY_MAX(MX), .HOLD_STEPS(HD1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .pause(pause),
        .duty_cycle(duty1), .phase(ph1), .step_tick(tk1), .peak(pk1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Trajectory tables: entry k = (duty, phase, peak) after k ticks since start
    int td[2][64], tp[2][64], tpk[2][64], per[2], sc[2];
    int m_run[2], m_cnt[2], m_k[2], m_lin[2], m_duty[2], m_ph[2], m_tick[2], m_peak[2];

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int gamma(input int l);
        return (l * l + 50) / 100;
    endfunction

    task automatic build(input int i, input int step, input int mx, input int hold);
        int n = 0;
        int d = 0;
        td[i][n] = 0; tp[i][n] = 1; tpk[i][n] = 0; n++;
        while (d < mx) begin
            d = (d + step > mx) ? mx : d + step;
            td[i][n] = d; tp[i][n] = (d == mx) ? 2 : 1; tpk[i][n] = (d == mx) ? 1 : 0; n++;
        end
        for (int j = 1; j <= hold; j++) begin
            td[i][n] = mx; tp[i][n] = (j == hold) ? 3 : 2; tpk[i][n] = 0; n++;
        end
        while (d > 0) begin
            d = (d - step < 0) ? 0 : d - step;
            td[i][n] = d; tp[i][n] = (d == 0) ? 0 : 3; tpk[i][n] = 0; n++;
        end
        for (int j = 1; j <= hold; j++) begin
            td[i][n] = 0; tp[i][n] = (j == hold) ? 1 : 0; tpk[i][n] = 0; n++;
        end
        per[i] = n - 1;
    endtask

    task automatic model_step(input int i);
        int prev_lin = m_lin[i];
        if (reset) begin
            m_run[i] = 0; m_cnt[i] = 0; m_k[i] = 0; m_lin[i] = 0;
            m_ph[i] = 0; m_tick[i] = 0; m_peak[i] = 0;
        end else if (!enable) begin
            m_run[i] = 0; m_cnt[i] = 0; m_k[i] = 0; m_lin[i] = 0;
            m_ph[i] = 0; m_tick[i] = 0; m_peak[i] = 0;
        end else if (pause) begin
            m_tick[i] = 0; m_peak[i] = 0;
        end else if (m_run[i] == 0) begin
            m_run[i] = 1; m_cnt[i] = 0; m_k[i] = 0; m_lin[i] = 0;
            m_ph[i] = 1; m_tick[i] = 0; m_peak[i] = 0;
        end else begin
            if (m_cnt[i] == sc[i] - 1) begin
                m_cnt[i]  = 0;
                m_k[i]    = (m_k[i] + 1) % per[i];
                m_tick[i] = 1;
                m_peak[i] = tpk[i][m_k[i]];
            end else begin
                m_cnt[i]++;
                m_tick[i] = 0;
                m_peak[i] = 0;
            end
            m_lin[i] = td[i][m_k[i]];
            m_ph[i]  = tp[i][m_k[i]];
        end
`ifdef GAMMA_EN
        m_duty[i] = reset ? 0 : gamma(prev_lin);
`else
        m_duty[i] = m_lin[i] + 0 * prev_lin;
`endif
    endtask

    task automatic cycle(input logic r, input logic e, input logic p);
        reset = r; enable = e; pause = p;
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
        check_eq("duty0",  int'(duty0), m_duty[0]);
        check_eq("phase0", int'(ph0),   m_ph[0]);
        check_eq("tick0",  int'(tk0),   m_tick[0]);
        check_eq("peak0",  int'(pk0),   m_peak[0]);
        check_eq("duty1",  int'(duty1), m_duty[1]);
        check_eq("phase1", int'(ph1),   m_ph[1]);
        check_eq("tick1",  int'(tk1),   m_tick[1]);
        check_eq("peak1",  int'(pk1),   m_peak[1]);
        check_eq("range1", (duty1 <= 7'd100) ? 1 : 0, 1);
    endtask

    initial begin
        int found;
        reset = 1'b1; enable = 1'b0; pause = 1'b0;
        sc[0] = SC0; sc[1] = SC1;
        build(0, ST0, MX, HD0);
        build(1, ST1, MX, HD1);

        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        repeat (130) cycle(1'b0, 1'b1, 1'b0);

        // Pause for 7 cycles while the STEP-10 build sits at 50 in RISE
        found = 0;
        for (int n = 0; n < 200 && found == 0; n++) begin
            if (m_ph[0] == 1 && m_lin[0] == 50) found = 1;
            else cycle(1'b0, 1'b1, 1'b0);
        end
        check_eq("reach_rise50", found, 1);
        repeat (7) cycle(1'b0, 1'b1, 1'b1);
        repeat (12) cycle(1'b0, 1'b1, 1'b0);

        // Drop enable at 70 in FALL on the same edge as a tick
        found = 0;
        for (int n = 0; n < 300 && found == 0; n++) begin
            if (m_ph[0] == 3 && m_lin[0] == 70 && m_cnt[0] == SC0 - 1) found = 1;
            else cycle(1'b0, 1'b1, 1'b0);
        end
        check_eq("reach_fall70", found, 1);
        cycle(1'b0, 1'b0, 1'b0);
        repeat (20) cycle(1'b0, 1'b1, 1'b0);

        // Reset mid-RISE while paused
        repeat (15) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        repeat (10) cycle(1'b0, 1'b1, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
